// File: rtl/keypad_code_lock.sv
// keypad_code_lock: 12-key code lock with timed open/lockout windows, two-pass code change, admin unlock.
// Latency: a key press is reflected on data/count_Wrong/state indicators right after the sampling edge.
// Backpressure: none; Key is sampled every cycle and a held key counts as a single press.
//
// Ports:
//   clock, reset      - rising-edge clock, asynchronous active-low reset
//   Key[11:0]         - one-hot keypad: [8:0] digits 1..9, [9] ENTER '#', [10] digit 0, [11] FUNC '*'
//   set_1             - admin unlock (level); returns to IDLE, clears attempts/entry/timers, keeps code
//   OPEN/LOCK         - open window / lockout window indicators
//   CHANGE/SET        - first pass / confirm pass of a new-code entry
//   SAVE_LIGHT        - new code stored; held until the next press, set_1 or reset
//   data              - BCD entry buffer, newest digit in the low nibble
//   count_Wrong       - consecutive wrong attempts
module keypad_code_lock #(
    parameter int                  DIGITS         = 4,
    parameter logic [4*DIGITS-1:0] DEFAULT_CODE   = 16'h1433,
    parameter int                  MAX_WRONG      = 3,
    parameter int                  OPEN_CYCLES    = 500,
    parameter int                  LOCKOUT_CYCLES = 1000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [11:0]         Key,
    input  logic                set_1,
    output logic                OPEN,
    output logic                LOCK,
    output logic                CHANGE,
    output logic                SET,
    output logic                SAVE_LIGHT,
    output logic [4*DIGITS-1:0] data,
    output logic [3:0]          count_Wrong
);

    localparam int W    = 4 * DIGITS;
    localparam int CW   = $clog2(DIGITS + 1);
    localparam int TMAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [CW-1:0] FULL      = CW'(DIGITS);
    localparam logic [TW-1:0] OPEN_LAST = TW'(OPEN_CYCLES - 1);
    localparam logic [TW-1:0] LOCK_LAST = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [3:0]    WRONG_MAX = 4'(MAX_WRONG);

    typedef enum logic [2:0] {
        IDLE,
        OPEN_S,
        LOCKOUT,
        NEW1,
        NEW2
    } state_t;

    state_t        state, state_nxt;
    logic [11:0]   key_q;
    logic [W-1:0]  entry, entry_nxt;
    logic [W-1:0]  code, code_nxt;
    logic [W-1:0]  cand, cand_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [3:0]    wrong, wrong_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic          save, save_nxt;

    logic          one_hot;
    logic          press;
    logic          is_enter;
    logic          is_func;
    logic          len_full;
    logic          full_match;
    logic          cand_match;
    logic [3:0]    digit;
    logic [3:0]    wrong_inc;
    logic [W-1:0]  entry_shift;

    // x & (x-1) clears the lowest set bit, so a non-zero result means multi-hot.
    assign one_hot    = (Key != 12'd0) && ((Key & (Key - 12'd1)) == 12'd0);
    assign press      = one_hot && (key_q == 12'd0);
    assign is_enter   = Key[9];
    assign is_func    = Key[11];
    assign len_full   = (cnt == FULL);
    assign full_match = len_full && (entry == code);
    assign cand_match = len_full && (entry == cand);
    assign wrong_inc  = wrong + 4'd1;
    // Shift form rather than a part-select so DIGITS=1 needs no special case.
    assign entry_shift = (entry << 4) | W'(digit);

    // Digit value of the pressed key; Key[10] ('0') falls through to the default.
    always_comb begin
        digit = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (Key[i]) begin
                digit = 4'(i + 1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        entry_nxt = entry;
        cnt_nxt   = cnt;
        wrong_nxt = wrong;
        timer_nxt = timer;
        code_nxt  = code;
        cand_nxt  = cand;
        save_nxt  = save & ~press;

        if (set_1) begin
            state_nxt = IDLE;
            wrong_nxt = 4'd0;
            timer_nxt = '0;
            save_nxt  = 1'b0;
            entry_nxt = '0;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (press) begin
                        if (is_enter || is_func) begin
                            if (full_match) begin
                                wrong_nxt = 4'd0;
                                state_nxt = is_enter ? OPEN_S : NEW1;
                            end else if (wrong_inc >= WRONG_MAX) begin
                                wrong_nxt = WRONG_MAX;
                                state_nxt = LOCKOUT;
                            end else begin
                                wrong_nxt = wrong_inc;
                            end
                        end else if (!len_full) begin
                            entry_nxt = entry_shift;
                            cnt_nxt   = cnt + CW'(1);
                        end
                    end
                end
                OPEN_S: begin
                    // Expiry is tested first so it wins over a coincident ENTER.
                    if (timer == OPEN_LAST || (press && is_enter)) begin
                        state_nxt = IDLE;
                    end else begin
                        timer_nxt = timer + TW'(1);
                    end
                end
                LOCKOUT: begin
                    if (timer == LOCK_LAST) begin
                        state_nxt = IDLE;
                        wrong_nxt = 4'd0;
                    end else begin
                        timer_nxt = timer + TW'(1);
                    end
                end
                NEW1: begin
                    if (press) begin
                        if (is_enter && len_full) begin
                            cand_nxt  = entry;
                            state_nxt = NEW2;
                        end else if (is_enter || is_func) begin
                            state_nxt = IDLE;
                        end else if (!len_full) begin
                            entry_nxt = entry_shift;
                            cnt_nxt   = cnt + CW'(1);
                        end
                    end
                end
                NEW2: begin
                    if (press) begin
                        if (is_enter && cand_match) begin
                            code_nxt = cand;
                            save_nxt = 1'b1;
                        end
                        // Aborts leave the attempt counter alone.
                        if (is_enter || is_func) begin
                            state_nxt = IDLE;
                        end else if (!len_full) begin
                            entry_nxt = entry_shift;
                            cnt_nxt   = cnt + CW'(1);
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase

            if (state_nxt != state || (press && (is_enter || is_func))) begin
                entry_nxt = '0;
                cnt_nxt   = '0;
            end
            if (state_nxt != state) begin
                timer_nxt = '0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            key_q <= 12'd0;
            entry <= '0;
            cnt   <= '0;
            wrong <= 4'd0;
            timer <= '0;
            code  <= DEFAULT_CODE;
            cand  <= '0;
            save  <= 1'b0;
        end else begin
            state <= state_nxt;
            key_q <= Key;
            entry <= entry_nxt;
            cnt   <= cnt_nxt;
            wrong <= wrong_nxt;
            timer <= timer_nxt;
            code  <= code_nxt;
            cand  <= cand_nxt;
            save  <= save_nxt;
        end
    end

    assign OPEN        = (state == OPEN_S);
    assign LOCK        = (state == LOCKOUT);
    assign CHANGE      = (state == NEW1);
    assign SET         = (state == NEW2);
    assign SAVE_LIGHT  = save;
    assign data        = entry;
    assign count_Wrong = wrong;

endmodule

// File: tb/tb_keypad_code_lock.sv
// tb_keypad_code_lock: self-checking bench for keypad_code_lock (DIGITS=4, code 1433, 3 tries, 20/50 cycles).
// Latency: outputs are sampled 1 time unit after each rising edge and compared with expectations.
// Backpressure: not applicable; stimulus is driven every cycle.
module tb_keypad_code_lock;

    localparam int MAX_WRONG = 3;
    localparam int OC        = 20;
    localparam int LC        = 50;

    localparam logic [11:0] K1 = 12'h001;
    localparam logic [11:0] K3 = 12'h004;
    localparam logic [11:0] K4 = 12'h008;
    localparam logic [11:0] K5 = 12'h010;
    localparam logic [11:0] K6 = 12'h020;
    localparam logic [11:0] K9 = 12'h100;
    localparam logic [11:0] KE = 12'h200;
    localparam logic [11:0] K0 = 12'h400;
    localparam logic [11:0] KF = 12'h800;
    localparam logic [11:0] KN = 12'h000;

    // {OPEN, LOCK, CHANGE, SET, SAVE_LIGHT}
    localparam logic [4:0] F_NONE = 5'b00000;
    localparam logic [4:0] F_OPEN = 5'b10000;
    localparam logic [4:0] F_CHG  = 5'b00100;
    localparam logic [4:0] F_SET  = 5'b00010;
    localparam logic [4:0] F_SAVE = 5'b00001;

    logic        clock = 1'b0;
    logic        reset;
    logic [11:0] Key;
    logic        set_1;
    logic        OPEN, LOCK, CHANGE, SET, SAVE_LIGHT;
    logic [15:0] data;
    logic [3:0]  count_Wrong;

    int total = 0;
    int bad   = 0;
    int n_open = 0;
    int n_lock = 0;

    keypad_code_lock #(
        .DIGITS(4), .DEFAULT_CODE(16'h1433), .MAX_WRONG(MAX_WRONG),
        .OPEN_CYCLES(OC), .LOCKOUT_CYCLES(LC)
    ) dut (
        .clock(clock), .reset(reset), .Key(Key), .set_1(set_1),
        .OPEN(OPEN), .LOCK(LOCK), .CHANGE(CHANGE), .SET(SET), .SAVE_LIGHT(SAVE_LIGHT),
        .data(data), .count_Wrong(count_Wrong)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] dut_obs();
        return {7'd0, OPEN, LOCK, CHANGE, SET, SAVE_LIGHT, count_Wrong, data};
    endfunction

    // ---------------- reference model ----------------
    // mode: 0 idle, 1 open, 2 lockout, 3 new-code first pass, 4 confirm pass
    int          m_mode;
    int          m_digs[$];
    int          m_code[4];
    int          m_cand[4];
    int          m_wrong;
    int          m_left;
    bit          m_save;
    logic [11:0] m_prev;

    task automatic model_reset();
        m_mode = 0;
        m_digs.delete();
        m_code = '{1, 4, 3, 3};
        m_cand = '{0, 0, 0, 0};
        m_wrong = 0;
        m_left = 0;
        m_save = 1'b0;
        m_prev = 12'd0;
    endtask

    // 0..9 digit, 10 ENTER, 11 FUNC, -1 nothing
    function automatic int key_kind(input logic [11:0] k);
        for (int i = 0; i < 12; i++) begin
            if (k[i]) begin
                if (i < 9) return i + 1;
                if (i == 10) return 0;
                if (i == 9) return 10;
                return 11;
            end
        end
        return -1;
    endfunction

    function automatic bit entered_is(input int c[4]);
        if (m_digs.size() != 4) return 1'b0;
        for (int i = 0; i < 4; i++) if (m_digs[i] != c[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step(input logic [11:0] k, input logic s1);
        bit press;
        int kind;
        int old_mode;
        press = ($countones(k) == 1) && (m_prev == 12'd0);
        m_prev = k;
        kind = key_kind(k);
        old_mode = m_mode;
        if (press) m_save = 1'b0;
        if (s1) begin
            m_mode = 0; m_wrong = 0; m_left = 0; m_save = 1'b0;
            m_digs.delete();
            return;
        end
        case (m_mode)
            1: begin
                m_left--;
                if (m_left == 0 || (press && kind == 10)) m_mode = 0;
            end
            2: begin
                m_left--;
                if (m_left == 0) begin m_mode = 0; m_wrong = 0; end
            end
            default: if (press) begin
                if (kind < 10) begin
                    if (m_digs.size() < 4) m_digs.push_back(kind);
                end else if (m_mode == 0) begin
                    if (entered_is(m_code)) begin
                        m_wrong = 0;
                        if (kind == 10) begin m_mode = 1; m_left = OC; end
                        else m_mode = 3;
                    end else begin
                        m_wrong++;
                        if (m_wrong == MAX_WRONG) begin m_mode = 2; m_left = LC; end
                    end
                end else if (m_mode == 3) begin
                    if (kind == 10 && m_digs.size() == 4) begin
                        for (int i = 0; i < 4; i++) m_cand[i] = m_digs[i];
                        m_mode = 4;
                    end else m_mode = 0;
                end else begin
                    if (kind == 10 && entered_is(m_cand)) begin
                        m_code = m_cand;
                        m_save = 1'b1;
                    end
                    m_mode = 0;
                end
            end
        endcase
        if (m_mode != old_mode || (press && kind >= 10)) m_digs.delete();
    endtask

    function automatic logic [31:0] model_obs();
        logic [15:0] d;
        d = 16'd0;
        foreach (m_digs[i]) d = {d[11:0], 4'(m_digs[i])};
        return {7'd0, m_mode == 1, m_mode == 2, m_mode == 3, m_mode == 4, m_save, 4'(m_wrong), d};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic cycle(input logic [11:0] k, input logic s1, input string tag);
        Key = k;
        set_1 = s1;
        @(posedge clock);
        model_step(k, s1);
        #1;
        if (OPEN) n_open++;
        if (LOCK) n_lock++;
        check(tag, dut_obs(), model_obs());
    endtask

    function automatic logic [11:0] dkey(input int d);
        logic [11:0] r;
        r = 12'd0;
        if (d == 0) r[10] = 1'b1;
        else r[d-1] = 1'b1;
        return r;
    endfunction

    task automatic press_key(input logic [11:0] k, input int hold, input int rel, input string tag);
        repeat (hold) cycle(k, 1'b0, tag);
        repeat (rel) cycle(KN, 1'b0, tag);
    endtask

    task automatic type_seq(input string s);
        logic [11:0] k;
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == "#") k = KE;
            else if (s[i] == "*") k = KF;
            else k = dkey(int'(s[i]) - int'("0"));
            press_key(k, 1, 1, {"seq ", s});
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            if (!OPEN && !LOCK) break;
            cycle(KN, 1'b0, "wait");
        end
        check("wait_timeout", {30'd0, OPEN, LOCK}, 32'd0);
    endtask

    task automatic do_reset();
        Key = KN;
        set_1 = 1'b0;
        reset = 1'b0;
        #3;
        check("reset_state", dut_obs(), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        model_reset();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [11:0] key;
        logic        s1;
        logic [24:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [11:0] k, input logic s1, input logic [4:0] f,
                       input logic [3:0] w, input logic [15:0] d);
        vec_t r;
        r.key = k;
        r.s1 = s1;
        r.exp = {f, w, d};
        tbl.push_back(r);
    endtask

    // Key press followed by a release cycle; outputs expected to stay the same over both.
    task automatic add2(input logic [11:0] k, input logic [4:0] f, input logic [3:0] w,
                        input logic [15:0] d);
        add(k, 1'b0, f, w, d);
        add(KN, 1'b0, f, w, d);
    endtask

    initial begin
        add(K1, 0, F_NONE, 0, 16'h1); add(K1, 0, F_NONE, 0, 16'h1); add(K1, 0, F_NONE, 0, 16'h1);
        add(KN, 0, F_NONE, 0, 16'h1);
        add(12'h00C, 0, F_NONE, 0, 16'h1); add(K4, 0, F_NONE, 0, 16'h1); add(KN, 0, F_NONE, 0, 16'h1);
        add2(K4, F_NONE, 0, 16'h14); add2(K3, F_NONE, 0, 16'h143); add2(K3, F_NONE, 0, 16'h1433);
        add2(K9, F_NONE, 0, 16'h1433);
        add2(KF, F_CHG, 0, 16'h0);
        add2(K1, F_CHG, 0, 16'h1); add2(K6, F_CHG, 0, 16'h16);
        add2(K3, F_CHG, 0, 16'h163); add2(K3, F_CHG, 0, 16'h1633);
        add2(KE, F_SET, 0, 16'h0);
        add2(K1, F_SET, 0, 16'h1); add2(K6, F_SET, 0, 16'h16);
        add2(K3, F_SET, 0, 16'h163); add2(K3, F_SET, 0, 16'h1633);
        add2(KE, F_SAVE, 0, 16'h0);
        add2(K1, F_NONE, 0, 16'h1); add2(K4, F_NONE, 0, 16'h14);
        add2(K3, F_NONE, 0, 16'h143); add2(K3, F_NONE, 0, 16'h1433);
        add2(KE, F_NONE, 1, 16'h0);
        add2(K1, F_NONE, 1, 16'h1); add2(K6, F_NONE, 1, 16'h16);
        add2(K3, F_NONE, 1, 16'h163); add2(K3, F_NONE, 1, 16'h1633);
        add2(KE, F_OPEN, 0, 16'h0);
        add2(K1, F_OPEN, 0, 16'h0);
        add2(KE, F_NONE, 0, 16'h0);
        add2(K5, F_NONE, 0, 16'h5); add2(K0, F_NONE, 0, 16'h50);
        add2(KF, F_NONE, 1, 16'h0);
        add(KN, 1, F_NONE, 0, 16'h0);
        add2(K5, F_NONE, 0, 16'h5);
        add(K1, 1, F_NONE, 0, 16'h0); add(KN, 0, F_NONE, 0, 16'h0);

        do_reset();

        foreach (tbl[i]) begin
            Key = tbl[i].key;
            set_1 = tbl[i].s1;
            @(posedge clock);
            #1;
            check($sformatf("vec%0d", i), dut_obs(), {7'd0, tbl[i].exp});
        end

        // Wrong attempts and lockout, with a correct code typed while locked.
        do_reset();
        type_seq("2433#"); check("wrong_1", 32'(count_Wrong), 32'd1);
        type_seq("2431#"); check("wrong_2", 32'(count_Wrong), 32'd2);
        n_lock = 0;
        type_seq("2432#"); check("wrong_3", 32'(count_Wrong), 32'd3);
        check("lock_on", 32'(LOCK), 32'd1);
        type_seq("1433#");
        check("locked_no_open", 32'(OPEN), 32'd0);
        check("locked_wrong", 32'(count_Wrong), 32'd3);
        wait_idle();
        check("lock_len", 32'(n_lock), 32'(LC));
        check("lock_wrong_clear", 32'(count_Wrong), 32'd0);

        // Correct code, full open window.
        type_seq("1433");
        check("entry_1433", 32'(data), 32'h1433);
        n_open = 0;
        type_seq("#");
        check("open_wrong", 32'(count_Wrong), 32'd0);
        wait_idle();
        check("open_len", 32'(n_open), 32'(OC));
        check("open_data_after", 32'(data), 32'd0);

        // Admin unlock mid-lockout.
        type_seq("1111#2222#3333#");
        check("admin_locked", 32'(LOCK), 32'd1);
        repeat (5) cycle(KN, 1'b0, "lock idle");
        cycle(KN, 1'b1, "admin");
        check("admin_lock", 32'(LOCK), 32'd0);
        check("admin_wrong", 32'(count_Wrong), 32'd0);
        type_seq("1433#");
        check("admin_open", 32'(OPEN), 32'd1);
        wait_idle();

        // Change aborted on a mismatched confirm.
        type_seq("1433*"); check("abort_change", 32'(CHANGE), 32'd1);
        type_seq("5555#"); check("abort_set", 32'(SET), 32'd1);
        type_seq("5556#");
        check("abort_idle", {27'd0, OPEN, LOCK, CHANGE, SET, SAVE_LIGHT}, 32'd0);
        check("abort_wrong", 32'(count_Wrong), 32'd0);
        type_seq("1433#"); check("abort_old_code", 32'(OPEN), 32'd1);
        wait_idle();

        // Held digit, short entries, fifth digit ignored, async reset in open.
        press_key(K5, 10, 1, "hold");
        check("hold_one_digit", 32'(data), 32'h5);
        type_seq("#"); check("short_1", 32'(count_Wrong), 32'd1);
        type_seq("143#"); check("short_3", 32'(count_Wrong), 32'd2);
        type_seq("14339#"); check("fifth_ignored", 32'(OPEN), 32'd1);
        repeat (3) cycle(KN, 1'b0, "open idle");
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_open", dut_obs(), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        model_reset();

        // Randomised traffic against the model.
        for (int it = 0; it < 350; it++) begin
            int r;
            logic [11:0] k;
            r = $urandom_range(0, 99);
            if (r < 35) begin
                k = 12'd0;
                k[$urandom_range(0, 11)] = 1'b1;
                press_key(k, $urandom_range(1, 3), $urandom_range(1, 2), "rnd key");
            end else if (r < 55) begin
                for (int i = 0; i < 4; i++) press_key(dkey(m_code[i]), 1, 1, "rnd code");
                press_key(($urandom_range(0, 1) == 0) ? KE : KF, 1, 1, "rnd code");
            end else if (r < 63) begin
                for (int i = 0; i < 4; i++) press_key(dkey(m_cand[i]), 1, 1, "rnd cand");
                press_key(KE, 1, 1, "rnd cand");
            end else if (r < 70) begin
                press_key(12'($urandom()), $urandom_range(1, 2), 1, "rnd multi");
            end else if (r < 73) begin
                cycle(12'($urandom()), 1'b1, "rnd admin");
            end else if (r < 82) begin
                repeat ($urandom_range(1, 60)) cycle(KN, 1'b0, "rnd wait");
            end else begin
                for (int i = 0; i < 4; i++) press_key(dkey($urandom_range(0, 9)), 1, 1, "rnd digits");
                press_key(KE, 1, 1, "rnd digits");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
